// File: rtl/kbd_decoder.sv
// PS/2 set-2 scancode decoder: pops bytes from a receiver FIFO, tracks E0/F0 prefixes,
// and reports the most recently pressed key with its ASCII value and a press counter.
module kbd_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_ready,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_overflow,
    output logic             ps2_nextdata_n,
    output logic             key_down,
    output logic [7:0]       cur_scancode,
    output logic             cur_ext,
    output logic [7:0]       cur_ascii,
    output logic [CNT_W-1:0] press_count,
    output logic             ovf_seen
);

    typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_nextdata_n;
    logic [7:0]         r_byte;
    logic               r_ext_flag;
    logic               r_brk_flag;
    logic               r_key_down;
    logic [7:0]         r_cur_scancode;
    logic               r_cur_ext;
    logic [7:0]         r_cur_ascii;
    logic [CNT_W-1:0]   r_press_count;
    logic               r_ovf_seen;
    logic               w_match;
    logic [7:0]         w_ascii;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (ps2_ready) w_state_next = POP;
            POP:     w_state_next = DECODE;
            DECODE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Same key means same code and same E0 qualification as the held key
    assign w_match = (r_byte == r_cur_scancode) && (r_ext_flag == r_cur_ext);

    always_comb begin
        w_ascii = 8'h00;
        case (r_byte)
            8'h1C: w_ascii = 8'h61;  8'h32: w_ascii = 8'h62;  8'h21: w_ascii = 8'h63;
            8'h23: w_ascii = 8'h64;  8'h24: w_ascii = 8'h65;  8'h2B: w_ascii = 8'h66;
            8'h34: w_ascii = 8'h67;  8'h33: w_ascii = 8'h68;  8'h43: w_ascii = 8'h69;
            8'h3B: w_ascii = 8'h6A;  8'h42: w_ascii = 8'h6B;  8'h4B: w_ascii = 8'h6C;
            8'h3A: w_ascii = 8'h6D;  8'h31: w_ascii = 8'h6E;  8'h44: w_ascii = 8'h6F;
            8'h4D: w_ascii = 8'h70;  8'h15: w_ascii = 8'h71;  8'h2D: w_ascii = 8'h72;
            8'h1B: w_ascii = 8'h73;  8'h2C: w_ascii = 8'h74;  8'h3C: w_ascii = 8'h75;
            8'h2A: w_ascii = 8'h76;  8'h1D: w_ascii = 8'h77;  8'h22: w_ascii = 8'h78;
            8'h35: w_ascii = 8'h79;  8'h1A: w_ascii = 8'h7A;
            8'h45: w_ascii = 8'h30;  8'h16: w_ascii = 8'h31;  8'h1E: w_ascii = 8'h32;
            8'h26: w_ascii = 8'h33;  8'h25: w_ascii = 8'h34;  8'h2E: w_ascii = 8'h35;
            8'h36: w_ascii = 8'h36;  8'h3D: w_ascii = 8'h37;  8'h3E: w_ascii = 8'h38;
            8'h46: w_ascii = 8'h39;
            8'h29: w_ascii = 8'h20;  8'h5A: w_ascii = 8'h0D;
            default: w_ascii = 8'h00;
        endcase
        if (r_ext_flag) w_ascii = 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nextdata_n   <= 1'b1;
            r_byte         <= 8'h00;
            r_ext_flag     <= 1'b0;
            r_brk_flag     <= 1'b0;
            r_key_down     <= 1'b0;
            r_cur_scancode <= 8'h00;
            r_cur_ext      <= 1'b0;
            r_cur_ascii    <= 8'h00;
            r_press_count  <= '0;
            r_ovf_seen     <= 1'b0;
        end else begin
            // Strobe is low exactly for the cycle spent in POP
            r_nextdata_n <= !((r_state == IDLE) && ps2_ready);
            if (ps2_overflow) r_ovf_seen <= 1'b1;
            if ((r_state == IDLE) && ps2_ready) r_byte <= ps2_data;
            if (r_state == DECODE) begin
                if (r_byte == 8'hE0) begin
                    r_ext_flag <= 1'b1;
                end else if (r_byte == 8'hF0) begin
                    r_brk_flag <= 1'b1;
                end else if (r_brk_flag) begin
                    if (w_match) r_key_down <= 1'b0;
                    r_brk_flag <= 1'b0;
                    r_ext_flag <= 1'b0;
                end else if (r_key_down && w_match) begin
                    r_ext_flag <= 1'b0;
                end else begin
                    r_cur_scancode <= r_byte;
                    r_cur_ext      <= r_ext_flag;
                    r_cur_ascii    <= w_ascii;
                    r_key_down     <= 1'b1;
                    r_press_count  <= r_press_count + CNT_W'(1);
                    r_ext_flag     <= 1'b0;
                end
            end
        end
    end

    assign ps2_nextdata_n = r_nextdata_n;
    assign key_down       = r_key_down;
    assign cur_scancode   = r_cur_scancode;
    assign cur_ext        = r_cur_ext;
    assign cur_ascii      = r_cur_ascii;
    assign press_count    = r_press_count;
    assign ovf_seen       = r_ovf_seen;

endmodule

// File: tb/tb_kbd_decoder.sv
// Testbench for kbd_decoder: FIFO-emulating driver, directed vector table,
// multi-cycle corner sequences and randomized bytes against a keyboard-state model.
module tb_kbd_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_ready = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_overflow = 1'b0;
    logic       ps2_nextdata_n;
    logic       key_down;
    logic [7:0] cur_scancode;
    logic       cur_ext;
    logic [7:0] cur_ascii;
    logic [7:0] press_count;
    logic       ovf_seen;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] fifo[$];
    int pulses[$];
    bit mon_en = 0;

    kbd_decoder #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ps2_ready(ps2_ready), .ps2_data(ps2_data),
        .ps2_overflow(ps2_overflow), .ps2_nextdata_n(ps2_nextdata_n),
        .key_down(key_down), .cur_scancode(cur_scancode), .cur_ext(cur_ext),
        .cur_ascii(cur_ascii), .press_count(press_count), .ovf_seen(ovf_seen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver FIFO: pop on the strobe, present the head byte
    always @(negedge clk) begin
        if (ps2_nextdata_n === 1'b0 && fifo.size() > 0) void'(fifo.pop_front());
        ps2_ready = (fifo.size() > 0);
        ps2_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end

    always @(negedge clk) if (mon_en && ps2_nextdata_n === 1'b0) pulses.push_back(cyc);

    // Keyboard-state model
    logic [7:0] letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
        8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,
        8'h22,8'h35,8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    bit m_pre_ext, m_pre_brk, m_down, m_ext;
    logic [7:0] m_code, m_ascii;
    int m_count;

    function automatic logic [7:0] ref_ascii(input logic [7:0] code, input bit ext);
        if (ext) return 8'h00;
        for (int i = 0; i < 26; i++) if (letter_codes[i] == code) return 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++) if (digit_codes[i] == code) return 8'h30 + 8'(i);
        if (code == 8'h29) return 8'h20;
        if (code == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_pre_ext = 0; m_pre_brk = 0; m_down = 0; m_ext = 0;
        m_code = 8'h00; m_ascii = 8'h00; m_count = 0;
    endtask

    task automatic model_apply(input logic [7:0] b);
        bit same_key;
        same_key = (b == m_code) && (m_pre_ext == m_ext);
        if (b == 8'hE0) m_pre_ext = 1;
        else if (b == 8'hF0) m_pre_brk = 1;
        else if (m_pre_brk) begin
            if (same_key) m_down = 0;
            m_pre_brk = 0; m_pre_ext = 0;
        end else if (m_down && same_key) begin
            m_pre_ext = 0;
        end else begin
            m_code = b; m_ext = m_pre_ext; m_ascii = ref_ascii(b, m_pre_ext);
            m_down = 1; m_count = (m_count + 1) % 256; m_pre_ext = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".key_down"}, 32'(key_down), 32'(m_down));
        chk({tag, ".scancode"}, 32'(cur_scancode), 32'(m_code));
        chk({tag, ".ext"}, 32'(cur_ext), 32'(m_ext));
        chk({tag, ".ascii"}, 32'(cur_ascii), 32'(m_ascii));
        chk({tag, ".count"}, 32'(press_count), 32'(m_count));
    endtask

    // Push bytes, wait (bounded) for the FIFO to drain and the last decode to land
    task automatic push_and_wait(input logic [7:0] bytes[$]);
        bit drained;
        @(posedge clk); #1;
        foreach (bytes[i]) begin
            fifo.push_back(bytes[i]);
            model_apply(bytes[i]);
        end
        drained = 0;
        for (int i = 0; i < 10 * bytes.size() + 20; i++) begin
            @(posedge clk); #1;
            if (fifo.size() == 0) begin drained = 1; break; end
        end
        if (!drained) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", fifo.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [7:0] q[$];
        q.push_back(b);
        push_and_wait(q);
        $display("byte %02h -> kd=%0b sc=%02h ext=%0b ascii=%02h cnt=%0d",
                 b, key_down, cur_scancode, cur_ext, cur_ascii, press_count);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    typedef struct {
        logic [7:0] b;
        logic       kd;
        logic [7:0] sc;
        logic       ext;
        logic [7:0] asc;
        int         cnt;
    } vec_t;
    vec_t vecs[22];

    initial begin
        vecs = '{
            '{8'h1C,1,8'h1C,0,8'h61,1}, '{8'hF0,1,8'h1C,0,8'h61,1}, '{8'h1C,0,8'h1C,0,8'h61,1},
            '{8'h1C,1,8'h1C,0,8'h61,2}, '{8'h1C,1,8'h1C,0,8'h61,2}, '{8'h1C,1,8'h1C,0,8'h61,2},
            '{8'h32,1,8'h32,0,8'h62,3}, '{8'hF0,1,8'h32,0,8'h62,3}, '{8'h1C,1,8'h32,0,8'h62,3},
            '{8'hE0,1,8'h32,0,8'h62,3}, '{8'h75,1,8'h75,1,8'h00,4}, '{8'hE0,1,8'h75,1,8'h00,4},
            '{8'hF0,1,8'h75,1,8'h00,4}, '{8'h75,0,8'h75,1,8'h00,4}, '{8'hE0,0,8'h75,1,8'h00,4},
            '{8'h75,1,8'h75,1,8'h00,5}, '{8'hF0,1,8'h75,1,8'h00,5}, '{8'h75,1,8'h75,1,8'h00,5},
            '{8'h29,1,8'h29,0,8'h20,6}, '{8'h5A,1,8'h5A,0,8'h0D,7}, '{8'hE0,1,8'h5A,0,8'h0D,7},
            '{8'h1C,1,8'h1C,1,8'h00,8}
        };
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.nextdata_n", 32'(ps2_nextdata_n), 32'd1);
        chk("rst.key_down", 32'(key_down), 32'd0);
        chk("rst.scancode", 32'(cur_scancode), 32'd0);
        chk("rst.ext", 32'(cur_ext), 32'd0);
        chk("rst.ascii", 32'(cur_ascii), 32'd0);
        chk("rst.count", 32'(press_count), 32'd0);
        chk("rst.ovf", 32'(ovf_seen), 32'd0);
        rst = 0;

        // Directed vector table
        foreach (vecs[i]) begin
            send_byte(vecs[i].b);
            chk($sformatf("vec%0d.key_down", i), 32'(key_down), 32'(vecs[i].kd));
            chk($sformatf("vec%0d.scancode", i), 32'(cur_scancode), 32'(vecs[i].sc));
            chk($sformatf("vec%0d.ext", i), 32'(cur_ext), 32'(vecs[i].ext));
            chk($sformatf("vec%0d.ascii", i), 32'(cur_ascii), 32'(vecs[i].asc));
            chk($sformatf("vec%0d.count", i), 32'(press_count), 32'(vecs[i].cnt));
        end

        // Four queued bytes: four single-cycle pops, three cycles apart
        begin
            logic [7:0] q[$];
            q = '{8'h16, 8'h1E, 8'h26, 8'h25};
            pulses.delete();
            mon_en = 1;
            push_and_wait(q);
            mon_en = 0;
            chk("burst.pulses", 32'(pulses.size()), 32'd4);
            for (int i = 1; i < pulses.size(); i++)
                chk($sformatf("burst.gap%0d", i), 32'(pulses[i] - pulses[i-1]), 32'd3);
            chk_model("burst");
            $display("burst: %0d pops, final sc=%02h cnt=%0d", pulses.size(), cur_scancode, press_count);
        end

        // Randomized bytes against the model
        for (int n = 0; n < 150; n++) begin
            logic [7:0] pool [10];
            logic [7:0] b;
            pool = '{8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h75, 8'h29, 8'h5A, 8'h16, 8'h45, 8'h00};
            b = pool[$urandom_range(0, 9)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            send_byte(b);
            chk_model($sformatf("rnd%0d", n));
        end

        // Counter wrap: 255 distinct presses, then one more
        do_reset();
        begin
            logic [7:0] q[$];
            for (int i = 0; i < 255; i++) q.push_back((i % 2 == 0) ? 8'h1C : 8'h32);
            push_and_wait(q);
            chk("wrap.count255", 32'(press_count), 32'd255);
            send_byte(8'h29);
            chk("wrap.count0", 32'(press_count), 32'd0);
            chk_model("wrap");
        end

        // Reset after E0 F0 discards the prefixes
        send_byte(8'hE0);
        send_byte(8'hF0);
        @(posedge clk); #2;
        rst = 1;
        #1;
        chk("midrst.key_down", 32'(key_down), 32'd0);
        chk("midrst.count", 32'(press_count), 32'd0);
        chk("midrst.nextdata_n", 32'(ps2_nextdata_n), 32'd1);
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        send_byte(8'h75);
        chk("midrst.make_kd", 32'(key_down), 32'd1);
        chk("midrst.make_ext", 32'(cur_ext), 32'd0);
        chk("midrst.make_cnt", 32'(press_count), 32'd1);
        chk_model("midrst");

        // Sticky overflow
        @(posedge clk); #1;
        ps2_overflow = 1;
        @(posedge clk); #1;
        ps2_overflow = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("ovf.set", 32'(ovf_seen), 32'd1);
        send_byte(8'h1C);
        chk("ovf.sticky", 32'(ovf_seen), 32'd1);
        chk_model("ovf");
        do_reset();
        chk("ovf.cleared", 32'(ovf_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
